// File: rtl/sigdelay_pkg.sv
// Shared types and default widths for the signal-delay sequencer and datapath.
package sigdelay_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } seq_state_t;

   localparam int OFFSET_W = 8;
   localparam int DIV_W    = 16;

endpackage

// File: rtl/delay_seq_ctrl_sample_tick.sv
// Sample-rate divider: tick_cnt counts while run is high and fires tick on
// the cycle where it equals div, then wraps to 0. Held at 0 when not running
// or when cleared.
module sample_tick #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 run,
   input  logic                 clr,
   input  logic [DIV_WIDTH-1:0] div,
   output logic                 tick
);

   logic [DIV_WIDTH-1:0] tick_cnt_q;
   logic [DIV_WIDTH-1:0] tick_cnt_d;

   // div is compared live so a new period applies at the next compare.
   assign tick = run && (tick_cnt_q == div);

   // Next count: hold at zero when idle/cleared, wrap on tick, else increment.
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      if (clr || !run) begin
         tick_cnt_d = '0;
      end else if (tick) begin
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
      end
   end

endmodule

// File: rtl/delay_seq_ctrl.sv
// Sequencer for the delay datapath: primes the RAM with `offset` writes,
// then issues paired write/read strobes and flags valid delayed data one
// cycle after each read. All outputs are registered.
module delay_seq_ctrl
   import sigdelay_pkg::*;
#(
   parameter int OFFSET_WIDTH = OFFSET_W,
   parameter int DIV_WIDTH    = DIV_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic [DIV_WIDTH-1:0]    div,
   input  logic [OFFSET_WIDTH-1:0] offset_in,
   input  logic                    offset_load,
   output logic [OFFSET_WIDTH-1:0] offset,
   output logic                    wr,
   output logic                    rd,
   output logic                    out_valid,
   output logic                    busy
);

   seq_state_t              state_q, state_d;
   logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
   logic [OFFSET_WIDTH-1:0] prime_cnt_q, prime_cnt_d;
   logic [OFFSET_WIDTH-1:0] prime_last;
   logic                    wr_q, wr_d;
   logic                    rd_q, rd_d;
   logic                    out_valid_q, out_valid_d;
   logic                    busy_q, busy_d;
   logic                    tick;
   logic                    tick_run;
   logic                    tick_clr;

   // The divider only counts while active and enabled, so it sits at zero in
   // IDLE and restarts cleanly on every entry to PRIME/RUN.
   assign tick_run = (state_q != IDLE) && en;

   sample_tick #(
      .DIV_WIDTH(DIV_WIDTH)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .run (tick_run),
      .clr (tick_clr),
      .div (div),
      .tick(tick)
   );

   // Last prime index; offset is never 0 while in PRIME so this cannot wrap.
   assign prime_last = offset_q - {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};

   // Next-state and output logic; priority is en drop, then load, then strobe.
   always_comb begin
      state_d     = state_q;
      offset_d    = offset_q;
      prime_cnt_d = prime_cnt_q;
      wr_d        = 1'b0;
      rd_d        = 1'b0;
      out_valid_d = rd_q;
      tick_clr    = 1'b0;
      case (state_q)
         IDLE: begin
            if (en) begin
               offset_d    = offset_in;
               prime_cnt_d = '0;
               state_d     = (offset_in != '0) ? PRIME : RUN;
            end
         end
         PRIME, RUN: begin
            if (!en) begin
               state_d = IDLE;
            end else if (offset_load) begin
               offset_d    = offset_in;
               prime_cnt_d = '0;
               tick_clr    = 1'b1;
               state_d     = (offset_in != '0) ? PRIME : RUN;
            end else if (tick) begin
               if (state_q == PRIME) begin
                  wr_d        = 1'b1;
                  prime_cnt_d = prime_cnt_q + {{(OFFSET_WIDTH-1){1'b0}}, 1'b1};
                  if (prime_cnt_q == prime_last) begin
                     state_d = RUN;
                  end
               end else begin
                  wr_d = 1'b1;
                  rd_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == PRIME);
   end

   // State and output registers; reset also drops any owed out_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         offset_q    <= '0;
         prime_cnt_q <= '0;
         wr_q        <= 1'b0;
         rd_q        <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         offset_q    <= offset_d;
         prime_cnt_q <= prime_cnt_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign offset    = offset_q;
   assign wr        = wr_q;
   assign rd        = rd_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_delay_seq_ctrl.sv
// Scoreboard bench for delay_seq_ctrl: the expected busy/out_valid/rd/wr
// pattern of every cycle is derived from the stimulus timeline and queued,
// then popped and compared as the DUT produces output.
module tb_delay_seq_ctrl;

   localparam int OW = 8;
   localparam int DW = 16;

   logic          clk;
   logic          rst;
   logic          en;
   logic [DW-1:0] div;
   logic [OW-1:0] offset_in;
   logic          offset_load;
   logic [OW-1:0] offset;
   logic          wr;
   logic          rd;
   logic          out_valid;
   logic          busy;

   delay_seq_ctrl #(
      .OFFSET_WIDTH(OW),
      .DIV_WIDTH   (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .div        (div),
      .offset_in  (offset_in),
      .offset_load(offset_load),
      .offset     (offset),
      .wr         (wr),
      .rd         (rd),
      .out_valid  (out_valid),
      .busy       (busy)
   );

   typedef struct {
      int       cyc;
      logic [3:0] bits;   // {busy, out_valid, rd, wr}
   } ev_t;

   ev_t        exp_q[$];
   logic [3:0] exp_a[int];
   int         cyc = 0;
   int         n_total = 0;
   int         n_bad = 0;
   logic [3:0] mon_got;
   ev_t        mon_ev;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int got, input int want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   function automatic void add_bits(input int c, input logic [3:0] v);
      if (!exp_a.exists(c)) exp_a[c] = 4'b0;
      exp_a[c] = exp_a[c] | v;
   endfunction

   // One run segment: en seen (or load seen) in cycle c0, period d+1, n prime
   // writes. Strobes up to and including cycle `cut` happen; keep_ov says
   // whether an out_valid falling after `cut` is still owed.
   task automatic add_seg(input int c0, input int d, input int n,
                          input int cut, input bit keep_ov);
      int s;
      if (n > 0) begin
         for (int c = c0 + 1; c <= c0 + d + 1 + (n - 1) * (d + 1) && c <= cut; c++)
            add_bits(c, 4'b1000);
      end
      for (int i = 0; ; i++) begin
         s = c0 + d + 2 + i * (d + 1);
         if (s > cut) break;
         add_bits(s, (i >= n) ? 4'b0011 : 4'b0001);
         if (i >= n && (keep_ov || s + 1 <= cut)) add_bits(s + 1, 4'b0100);
      end
   endtask

   task automatic at(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: compare every cycle that either the DUT or the model marks.
   always @(negedge clk) begin
      if (cyc >= 3) begin
         mon_got = {busy, out_valid, rd, wr};
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check($sformatf("missed@%0d", exp_q[0].cyc), 0, int'(exp_q[0].bits));
            void'(exp_q.pop_front());
         end
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_ev = exp_q.pop_front();
            $display("ev cyc=%0d busy/ov/rd/wr got=%b want=%b", cyc, mon_got, mon_ev.bits);
            check($sformatf("outs@%0d", cyc), int'(mon_got), int'(mon_ev.bits));
         end else if (mon_got != 4'b0) begin
            check($sformatf("spurious@%0d", cyc), int'(mon_got), 0);
         end
      end
   end

   initial begin
      rst         = 1'b1;
      en          = 1'b0;
      div         = 16'd3;
      offset_in   = 8'd4;
      offset_load = 1'b0;

      // Expected timeline (see stimulus below).
      add_seg(10, 3, 4, 35, 1'b1);     // normal start, cut by offset load
      add_seg(35, 3, 2, 52, 1'b0);     // re-prime, cut by reset (ov dropped)
      add_seg(55, 3, 2, 71, 1'b1);     // restart after reset, en drop at hit
      add_seg(80, 0, 0, 90, 1'b1);     // zero offset, en drop with owed ov
      add_seg(100, 0, 255, 360, 1'b1); // max offset
      foreach (exp_a[k]) exp_q.push_back('{k, exp_a[k]});
      exp_a.delete();

      at(4);
      check("rst_offset", int'(offset), 0);
      check("rst_outs", int'({busy, out_valid, rd, wr}), 0);
      at(5);  rst = 1'b0;
      at(10); en = 1'b1;
      at(11); check("offset_start", int'(offset), 4);
      at(35); offset_in = 8'd2; offset_load = 1'b1;
      at(36); offset_load = 1'b0;
              check("offset_reload", int'(offset), 2);
      at(52); rst = 1'b1;
      at(54); check("offset_in_rst", int'(offset), 0);
      at(55); rst = 1'b0;
      at(56); check("offset_restart", int'(offset), 2);
      at(71); en = 1'b0;
      at(75); offset_in = 8'd0; div = 16'd0;
      at(80); en = 1'b1;
      at(90); en = 1'b0;
      at(95); offset_in = 8'd255;
      at(100); en = 1'b1;
      at(200); check("offset_max", int'(offset), 255);
      at(360); en = 1'b0;
      at(370);
      check("drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
